// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a combinational ROM from fetch_pc and holds one
// fetched instruction in an IR with valid/ready handoff. Optional FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_data,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] fetch_count,
  output logic        misalign_exc,
  output logic [1:0]  dbg_state
);

  // Handshake: the IR is consumed on a rising edge where ir_valid && ir_ready && !redirect;
  // a redirect discards the IR contents without a handoff.
`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, VALID = 2'd1, FAULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, VALID = 2'd1} state_t;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] instr_n, pc_n, count_n;
  logic        load;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_n;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      instr       <= NOP;
      pc          <= RESET_PC;
      fetch_count <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      instr       <= instr_n;
      pc          <= pc_n;
      fetch_count <= count_n;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q  <= misalign_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    instr_n    = instr;
    pc_n       = pc;
    count_n    = fetch_count;
    load       = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_n = misalign_q;
`endif
    if (redirect) begin
      state_n = IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_pc_n = redirect_pc;
      misalign_n = (redirect_pc[1:0] != 2'b00);
      if (misalign_n) state_n = FAULT;
`else
      fetch_pc_n = {redirect_pc[31:2], 2'b00};
`endif
    end else begin
      case (state)
        IDLE:  load = fetch_en;
        VALID: if (ir_ready) begin
                 load = fetch_en;
                 if (!fetch_en) state_n = IDLE;
               end
        default: ;  // FAULT waits for an aligned redirect
      endcase
    end
    if (load) begin
      instr_n    = instr_data;
      pc_n       = fetch_pc;
      fetch_pc_n = fetch_pc + 32'd4;
      count_n    = fetch_count + 32'd1;
      state_n    = VALID;
    end
  end

  assign instr_addr = fetch_pc;
  assign ir_valid   = (state == VALID);
  assign pc_plus4   = pc + 32'd4;
  assign dbg_state  = state;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_exc = misalign_q;
`else
  assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vectors, scoreboard queue of {pc,instr} popped by a
// monitor on every IR handoff, plus direct register checks.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_addr, instr_data, redirect_pc, instr, pc, pc_plus4, fetch_count;
  logic        fetch_en, redirect, ir_valid, ir_ready, misalign_exc;
  logic [1:0]  dbg_state;

  logic [31:0] w_addr, w_data, w_instr, w_pc, w_pc_plus4, w_count;
  logic        w_fetch_en, w_ir_valid, w_misalign;
  logic [1:0]  w_state;

  logic [63:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'd0) ? 32'h0050_0513 : {8'hA5, a[23:0]};
  endfunction

  assign instr_data = rom(instr_addr);
  assign w_data     = rom(w_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_data(instr_data),
    .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .instr(instr), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_count(fetch_count), .misalign_exc(misalign_exc),
    .dbg_state(dbg_state)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .instr_addr(w_addr), .instr_data(w_data),
    .fetch_en(w_fetch_en), .redirect(1'b0), .redirect_pc(32'd0),
    .ir_valid(w_ir_valid), .ir_ready(1'b0), .instr(w_instr), .pc(w_pc),
    .pc_plus4(w_pc_plus4), .fetch_count(w_count), .misalign_exc(w_misalign),
    .dbg_state(w_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handoff happens on the coming edge when valid && ready && !redirect.
  always @(negedge clk) begin
    if (!reset && ir_valid && ir_ready && !redirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL handoff: got pc=%h instr=%h expected no handoff", pc, instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({pc, instr} !== e) begin
          failures++;
          $display("FAIL handoff: got pc=%h instr=%h expected pc=%h instr=%h",
                   pc, instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    ir_ready = 1'b0; w_fetch_en = 1'b0;
    tick(); tick();
    chk("rst_addr", instr_addr, 32'd0);
    chk("rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_misalign", {31'd0, misalign_exc}, 32'd0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    reset = 1'b0;
    tick();

    // first fetch, 1-cycle latency
    fetch_en = 1'b1; ir_ready = 1'b1;
    exp_q.push_back({32'd0, 32'h0050_0513});
    tick();
    fetch_en = 1'b0;
    chk("f1_valid", {31'd0, ir_valid}, 32'd1);
    chk("f1_instr", instr, 32'h0050_0513);
    chk("f1_pc", pc, 32'd0);
    chk("f1_pc4", pc_plus4, 32'd4);
    chk("f1_addr", instr_addr, 32'd4);
    chk("f1_count", fetch_count, 32'd1);
    tick();
    chk("f1_idle", {31'd0, ir_valid}, 32'd0);

    // stall with fetch_en held high
    fetch_en = 1'b1; ir_ready = 1'b0;
    exp_q.push_back({32'd4, rom(32'd4)});
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr, rom(32'd4));
      chk("stall_pc", pc, 32'd4);
      chk("stall_addr", instr_addr, 32'd8);
      chk("stall_count", fetch_count, 32'd2);
    end
    // back-to-back
    ir_ready = 1'b1;
    exp_q.push_back({32'd8, rom(32'd8)});
    tick();
    fetch_en = 1'b0;
    chk("b2b_valid", {31'd0, ir_valid}, 32'd1);
    chk("b2b_pc", pc, 32'd8);
    chk("b2b_count", fetch_count, 32'd3);
    tick();

    // wrap-around instance: one fetch from 0xFFFFFFFC
    w_fetch_en = 1'b1;
    tick();
    w_fetch_en = 1'b0;
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", w_pc_plus4, 32'd0);
    chk("wrap_addr", w_addr, 32'd0);
    chk("wrap_instr", w_instr, rom(32'hFFFF_FFFC));
    chk("wrap_count", w_count, 32'd1);

    // redirect overrides fetch_en and discards the held instruction
    fetch_en = 1'b1; ir_ready = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h20; ir_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("redir_valid", {31'd0, ir_valid}, 32'd0);
    chk("redir_addr", instr_addr, 32'h20);
    chk("redir_count", fetch_count, 32'd4);
    exp_q.push_back({32'h20, rom(32'h20)});
    tick();
    fetch_en = 1'b0;
    chk("redir_pc", pc, 32'h20);
    chk("redir_instr", instr, 32'hA500_0020);
    tick();

    // misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h22;
    tick();
    redirect = 1'b0; fetch_en = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
    chk("mis_addr", instr_addr, 32'h22);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("fault_hold_exc", {31'd0, misalign_exc}, 32'd1);
      chk("fault_hold_valid", {31'd0, ir_valid}, 32'd0);
      chk("fault_hold_count", fetch_count, 32'd5);
    end
`else
    chk("mis_exc", {31'd0, misalign_exc}, 32'd0);
    chk("mis_addr", instr_addr, 32'h20);
    fetch_en = 1'b0;
`endif
    redirect = 1'b1; redirect_pc = 32'h24;
    tick();
    redirect = 1'b0; fetch_en = 1'b0;
    chk("realign_exc", {31'd0, misalign_exc}, 32'd0);
    chk("realign_addr", instr_addr, 32'h24);
    chk("realign_valid", {31'd0, ir_valid}, 32'd0);
    fetch_en = 1'b1;
    exp_q.push_back({32'h24, rom(32'h24)});
    tick();
    fetch_en = 1'b0;
    chk("realign_count", fetch_count, 32'd6);
    tick();

    // reset mid-operation
    fetch_en = 1'b1; ir_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, ir_valid}, 32'd0);
    chk("mrst_count", fetch_count, 32'd0);
    chk("mrst_addr", instr_addr, 32'd0);
    chk("mrst_instr", instr, 32'h0000_0013);
    tick();
    reset = 1'b0; ir_ready = 1'b1;
    exp_q.push_back({32'd0, 32'h0050_0513});
    tick();
    fetch_en = 1'b0;
    chk("mrst_refetch_pc", pc, 32'd0);
    chk("mrst_refetch_count", fetch_count, 32'd1);
    tick();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending handoffs expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
